// File: rtl/pcie_lane_train_ctrl.sv
// pcie_lane_train_ctrl: PCIe link-training sequencer (detect, per-lane TS1 lock and polarity, link up).
// Define PCIE_LTC_AUTO_INVERT_EN to enable receive polarity auto-inversion.
module pcie_lane_train_ctrl #(
  parameter int LinkWidth     = 16,
  parameter int DetectCycles  = 16,
  parameter int LockCount     = 8,
  parameter int TimeoutCycles = 4096
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [10*LinkWidth-1:0] RxSymbols,
  input  logic [LinkWidth-1:0]    RxElecIdle,
  output logic [LinkWidth-1:0]    TxElecIdle,
  output logic [LinkWidth-1:0]    InvertLanes,
  output logic [LinkWidth-1:0]    LaneLocked,
  output logic                    LinkUp,
  output logic [1:0]              State
);
  typedef enum logic [1:0] {IDLE, DETECT, TRAIN, UP} state_t;
  localparam logic [3:0]  LOCK    = 4'(LockCount);
  localparam logic [15:0] DET_END = 16'(DetectCycles - 1);
  localparam logic [15:0] TO_END  = 16'(TimeoutCycles - 1);
  state_t st, ns;
  logic [15:0] cnt;
  logic any_idle;
  logic [9:0] sym [LinkWidth];
  logic [3:0] idx [LinkWidth];
  logic [3:0] idx_n [LinkWidth];
  logic [3:0] lcnt [LinkWidth];
  logic [3:0] lcnt_n [LinkWidth];
  logic [LinkWidth-1:0] cand, cand_n, lock_n, nrm, inv;
  assign any_idle = |RxElecIdle;
  assign State = st;
  always_comb
    ns = !Enable ? IDLE :
         st == IDLE ? DETECT :
         st == DETECT ? ((!any_idle && cnt == DET_END) ? TRAIN : DETECT) :
         st == TRAIN ? (&LaneLocked ? UP : cnt == TO_END ? DETECT : TRAIN) :
         any_idle ? DETECT : UP;
  // The identifier sits at index 6 of an ordered set, counted from the COM at index 0.
  always_comb
    for (int i = 0; i < LinkWidth; i++) begin
      sym[i] = RxSymbols[10*i +: 10];
      nrm[i] = sym[i] == 10'h155;
`ifdef PCIE_LTC_AUTO_INVERT_EN
      inv[i] = sym[i] == 10'h2AA;
`else
      inv[i] = 1'b0;
`endif
      idx_n[i] = (sym[i] == 10'h17C || sym[i] == 10'h283) ? 4'd1 :
                 idx[i] != 4'd0 ? idx[i] + 4'd1 : 4'd0;
      cand_n[i] = cand[i];
      lcnt_n[i] = lcnt[i];
      if (idx[i] == 4'd6) begin
        if (!nrm[i] && !inv[i]) lcnt_n[i] = 4'd0;
        else if (inv[i] == cand[i]) lcnt_n[i] = lcnt[i] == LOCK ? LOCK : lcnt[i] + 4'd1;
        else begin
          cand_n[i] = inv[i];
          lcnt_n[i] = 4'd1;
        end
      end
      lock_n[i] = lcnt_n[i] == LOCK;
    end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      st          <= IDLE;
      cnt         <= '0;
      TxElecIdle  <= '1;
      InvertLanes <= '0;
      LaneLocked  <= '0;
      LinkUp      <= 1'b0;
      cand        <= '0;
      idx         <= '{default: '0};
      lcnt        <= '{default: '0};
    end else begin
      st          <= ns;
      cnt         <= (ns != st || (st == DETECT && any_idle)) ? '0 :
                     (st == DETECT || st == TRAIN) ? cnt + 16'd1 : cnt;
      TxElecIdle  <= (ns == IDLE || ns == DETECT) ? '1 : '0;
      InvertLanes <= ns != UP ? '0 : st == TRAIN ? cand : InvertLanes;
      LinkUp      <= ns == UP;
      if (ns == TRAIN && st != TRAIN) begin
        cand       <= '0;
        LaneLocked <= '0;
        idx        <= '{default: '0};
        lcnt       <= '{default: '0};
      end else if (st == TRAIN) begin
        cand       <= cand_n;
        LaneLocked <= lock_n;
        idx        <= idx_n;
        lcnt       <= lcnt_n;
      end
    end
endmodule

// File: doc/pcie_lane_train_ctrl.md
# pcie_lane_train_ctrl

Link-training sequencer for the parallel (10-bit symbol) side of the PCIe virtual host. Drives transmit electrical idle and waits for all receive lanes to leave electrical idle. It then detects per-lane TS1 ordered sets and receive polarity, and declares the link up once every lane has locked. Its outputs configure the lane datapath: idle control, per-lane receive inversion and link status.

## Interface
Parameters:
- LinkWidth, 16, number of active lanes (1-16).
- DetectCycles, 16, consecutive cycles with all lanes out of idle needed to leave DETECT (1-65535).
- LockCount, 8, consecutive consistent TS1 identifiers needed per lane to lock (1-15).
- TimeoutCycles, 4096, TRAIN cycles before returning to DETECT (2-65535).

Ports:
- Clk  input  1  clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  training enable; low forces IDLE.
- RxSymbols  input  10*LinkWidth  received 10-bit symbols, lane i at [10*i+9:10*i].
- RxElecIdle  input  LinkWidth  per-lane receive electrical-idle flag.
- TxElecIdle  output  LinkWidth  per-lane transmit electrical-idle request.
- InvertLanes  output  LinkWidth  per-lane receive polarity inversion.
- LaneLocked  output  LinkWidth  per-lane lock status.
- LinkUp  output  1  link trained.
- State  output  2  current state encoding.

## Operation
- States:
  - IDLE=0, DETECT=1, TRAIN=2, UP=3.
- Transitions:
  - Enable low from any state goes to IDLE, with priority over all other transitions.
  - IDLE goes to DETECT when Enable is high.
  - DETECT goes to TRAIN when the 16-bit counter reaches DetectCycles-1 with RxElecIdle all zero. Any lane idle clears the counter.
  - TRAIN goes to UP when LaneLocked is all ones. It goes to DETECT when the counter reaches TimeoutCycles-1. If both occur in the same cycle, UP wins.
  - UP goes to DETECT when any RxElecIdle bit is high.
- Counter:
  - Clears on every state change.
  - Increments in DETECT and TRAIN only.
- Per-lane symbol tracker (active in TRAIN only; cleared on entry to TRAIN):
  - A COM symbol is 10'h17C or 10'h283. On COM, the 4-bit index is set to 1.
  - Otherwise, a nonzero index increments, wrapping 15 to 0.
- Identifier check when the index is 6:
  - 10'h155 means normal polarity.
  - 10'h2AA means inverted polarity.
  - Any other symbol is a mismatch: the lock count clears to 0 and LaneLocked drops.
- Valid identifier handling:
  - If its polarity equals the lane candidate, the lock count increments, saturating at LockCount.
  - Otherwise the candidate takes the new polarity and the count becomes 1.
- LaneLocked[i] is high when count[i]==LockCount.
- InvertLanes latches the candidate vector on the TRAIN-to-UP transition. It holds in UP and clears on entering IDLE or DETECT.
- TxElecIdle:
  - All ones in IDLE and DETECT.
  - All zeros in TRAIN and UP.
- LinkUp = (State==UP).

## Timing
- Reset values:
  - State=IDLE, TxElecIdle all ones, InvertLanes=0, LaneLocked=0, LinkUp=0.
  - Counter, indices, candidates and lock counts all 0.
- All outputs are registered, with no combinational path from input to output.
- RxSymbols and RxElecIdle are sampled at the edge and take effect on the same edge.
- Minimum DETECT duration is DetectCycles cycles. A COM arriving on the first TRAIN cycle is counted.
- Lock latency: the lane locks on the edge that samples the LockCount-th consistent identifier. LinkUp rises one edge after the last lane locks.
- Reset mid-operation returns to the reset values immediately (asynchronous). Deasserting Enable takes effect on the next edge.

## Configuration
- PCIE_LTC_AUTO_INVERT_EN:
  - Defined: polarity detection as above.
  - Undefined: 10'h2AA is treated as a mismatch, candidates are forced to normal, and InvertLanes stays all zeros.

## Test plan
- Basic train:
  - Stimulus: LinkWidth=4, Enable high, lanes out of idle, then TS1s on all lanes.
  - Response: TRAIN is entered 16 cycles after DETECT entry; LinkUp=1 after the 8th TS1 per lane; InvertLanes=0.
- Inverted lane (macro defined):
  - Stimulus: lane 2 sends identifier 10'h2AA.
  - Response: LinkUp=1 with InvertLanes=4'b0100. With the macro undefined, no lock occurs and the block times out to DETECT at 4096 cycles.
- Idle glitch:
  - Stimulus: lane 1 idle for one cycle at DETECT count 10.
  - Response: the counter restarts; TRAIN is entered 16 cycles after idle clears.
- Polarity flip:
  - Stimulus: a lane alternates 10'h155 and 10'h2AA identifiers.
  - Response: its count never exceeds 1; timeout returns to DETECT.
- Link drop:
  - Stimulus: in UP, RxElecIdle[0]=1.
  - Response: next edge State=DETECT, LinkUp=0, TxElecIdle all ones, InvertLanes cleared.
- Reset and enable:
  - Stimulus: Reset asserted mid-TRAIN.
  - Response: outputs return immediately to the reset values. Then, with Enable low after reset, State stays at IDLE.
